// File: rtl/cpu_pkg.sv
// Shared opcode, field-position and state definitions for the execution controller.
package cpu_pkg;

  // Instruction field positions
  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 11;
  localparam int unsigned RdMsb     = 10;
  localparam int unsigned RdLsb     = 8;
  localparam int unsigned RsMsb     = 7;
  localparam int unsigned RsLsb     = 5;
  localparam int unsigned RtMsb     = 4;
  localparam int unsigned RtLsb     = 2;
  localparam int unsigned ImmMsb    = 4;
  localparam int unsigned ImmLsb    = 0;

  // Bit positions inside the {c,z,n,o} flag vector
  localparam int unsigned FlagC = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagO = 0;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OpAdd  = 5'b00000;
  localparam opcode_t OpSub  = 5'b00001;
  localparam opcode_t OpAddi = 5'b00010;
  localparam opcode_t OpAnd  = 5'b00011;
  localparam opcode_t OpOr   = 5'b00100;
  localparam opcode_t OpXor  = 5'b00101;
  localparam opcode_t OpNot  = 5'b00110;
  localparam opcode_t OpMov  = 5'b00111;
  localparam opcode_t OpRor  = 5'b01000;
  localparam opcode_t OpRol  = 5'b01001;
  localparam opcode_t OpShr  = 5'b01010;
  localparam opcode_t OpShl  = 5'b01011;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  // Which flags an opcode is allowed to update; FlgNone marks an illegal opcode
  typedef enum logic [1:0] {FlgAll, FlgZn, FlgCzn, FlgNone} flag_class_e;

  function automatic flag_class_e flag_class(input opcode_t op);
    if (op <= OpAddi) begin
      return FlgAll;
    end else if (op <= OpMov) begin
      return FlgZn;
    end else if (op <= OpShl) begin
      return FlgCzn;
    end
    return FlgNone;
  endfunction

  function automatic logic [15:0] sext_imm5(input logic [4:0] imm);
    return {{11{imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Instruction handshake, external ALU, status and debug-read signals of exec_ctrl.
interface exec_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_s;
  logic [15:0] alu_r;
  logic        alu_c;
  logic        alu_z;
  logic        alu_n;
  logic        alu_o;
  logic        done;
  logic        illegal;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  // Instruction source / ALU / debug side
  modport master (
    output instr_valid, instr, alu_r, alu_c, alu_z, alu_n, alu_o, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_s, done, illegal, flags, dbg_data
  );

  // exec_ctrl side
  modport slave (
    input  instr_valid, instr, alu_r, alu_c, alu_z, alu_n, alu_o, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_s, done, illegal, flags, dbg_data
  );
endinterface

// File: rtl/regfile.sv
// 8x16 register file: one synchronous write port, three combinational read ports.
module regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [2:0]  raddr_a_i,
  output logic [15:0] rdata_a_o,
  input  logic [2:0]  raddr_b_i,
  output logic [15:0] rdata_b_o,
  input  logic [2:0]  raddr_d_i,
  output logic [15:0] rdata_d_o
);

  logic [15:0] mem_q [8];
  logic [15:0] mem_d [8];

  // Next-state: only the addressed entry changes on a write
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
  assign rdata_d_o = mem_q[raddr_d_i];

endmodule

// File: rtl/exec_ctrl.sv
// Four-phase (IDLE/READ/EXEC/WRITE) instruction sequencer around an external ALU.
module exec_ctrl
  import cpu_pkg::*;
#(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input logic         clk,
  input logic         rst_n,
  exec_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  aflags_q, aflags_d;
  logic [3:0]  flags_q, flags_d;
  logic        rf_we;

  opcode_t     op;
  flag_class_e fclass;
  logic [2:0]  rd, rs, rt;
  logic [15:0] rs_data, rt_data;

  assign op     = instr_q[OpcodeMsb:OpcodeLsb];
  assign rd     = instr_q[RdMsb:RdLsb];
  assign rs     = instr_q[RsMsb:RsLsb];
  assign rt     = instr_q[RtMsb:RtLsb];
  assign fclass = flag_class(op);

  regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (res_q),
    .raddr_a_i (rs),
    .rdata_a_o (rs_data),
    .raddr_b_i (rt),
    .rdata_b_o (rt_data),
    .raddr_d_i (bus.dbg_addr),
    .rdata_d_o (bus.dbg_data)
  );

  // Next-state, operand/result latching and flag update
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    aflags_d = aflags_q;
    flags_d  = flags_q;
    rf_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = StRead;
        end
      end
      StRead: begin
        opa_d = rs_data;
        if (op == OpAddi) begin
          opb_d = sext_imm5(instr_q[ImmMsb:ImmLsb]);
        end else if (op == OpRor || op == OpRol) begin
          // Rotates go through carry: the ALU sees the current c as its B operand
          opb_d = {15'b0, flags_q[FlagC]};
        end else begin
          opb_d = rt_data;
        end
        state_d = StExec;
      end
      StExec: begin
        res_d    = bus.alu_r;
        aflags_d = {bus.alu_c, bus.alu_z, bus.alu_n, bus.alu_o};
        state_d  = StWrite;
      end
      StWrite: begin
        rf_we = (fclass != FlgNone);
        unique case (fclass)
          FlgAll: flags_d = aflags_q;
          FlgZn: begin
            flags_d[FlagZ] = aflags_q[FlagZ];
            flags_d[FlagN] = aflags_q[FlagN];
          end
          FlgCzn: begin
            flags_d[FlagC] = aflags_q[FlagC];
            flags_d[FlagZ] = aflags_q[FlagZ];
            flags_d[FlagN] = aflags_q[FlagN];
          end
          FlgNone: flags_d = flags_q;
        endcase
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      instr_q  <= 16'h0000;
      opa_q    <= 16'h0000;
      opb_q    <= 16'h0000;
      res_q    <= 16'h0000;
      aflags_q <= 4'b0000;
      flags_q  <= FLAGS_INIT;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      aflags_q <= aflags_d;
      flags_q  <= flags_d;
    end
  end

  // ALU operands are only meaningful in EXEC but are driven from the latches always
  assign bus.alu_a       = opa_q;
  assign bus.alu_b       = opb_q;
  assign bus.alu_s       = op[3:0];
  assign bus.instr_ready = (state_q == StIdle);
  assign bus.done        = (state_q == StWrite);
  assign bus.illegal     = (state_q == StWrite) && (fclass == FlgNone);
  assign bus.flags       = flags_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed, table-driven bench for exec_ctrl with a behavioural ALU model.
module tb_exec_ctrl;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  exec_ctrl_if bus ();

  exec_ctrl #(
    .FLAGS_INIT (4'b0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: carry is carry-out for add, not-borrow for subtract
  logic [16:0] m_sum;
  logic [15:0] m_r;
  logic        m_c;
  logic        m_o;
  always_comb begin
    m_sum = 17'h0;
    m_r   = 16'h0;
    m_c   = 1'b0;
    m_o   = 1'b0;
    case (bus.alu_s)
      4'd0, 4'd2: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_r   = m_sum[15:0];
        m_c   = m_sum[16];
        m_o   = (bus.alu_a[15] == bus.alu_b[15]) && (m_r[15] != bus.alu_a[15]);
      end
      4'd1: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
        m_r   = m_sum[15:0];
        m_c   = m_sum[16];
        m_o   = (bus.alu_a[15] != bus.alu_b[15]) && (m_r[15] != bus.alu_a[15]);
      end
      4'd3: m_r = bus.alu_a & bus.alu_b;
      4'd4: m_r = bus.alu_a | bus.alu_b;
      4'd5: m_r = bus.alu_a ^ bus.alu_b;
      4'd6: m_r = ~bus.alu_a;
      4'd7: m_r = bus.alu_a;
      4'd8: begin m_r = {bus.alu_b[0], bus.alu_a[15:1]}; m_c = bus.alu_a[0];  end
      4'd9: begin m_r = {bus.alu_a[14:0], bus.alu_b[0]}; m_c = bus.alu_a[15]; end
      4'd10: begin m_r = {1'b0, bus.alu_a[15:1]}; m_c = bus.alu_a[0];  end
      4'd11: begin m_r = {bus.alu_a[14:0], 1'b0}; m_c = bus.alu_a[15]; end
      default: m_r = 16'h0;
    endcase
  end
  assign bus.alu_r = m_r;
  assign bus.alu_c = m_c;
  assign bus.alu_z = (m_r == 16'h0);
  assign bus.alu_n = m_r[15];
  assign bus.alu_o = m_o;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [4:0]  lo;
    logic [15:0] exp_r;
    logic [3:0]  exp_f;
    logic        exp_ill;
    logic        chk_b;
    logic [15:0] exp_b;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [4:0] lo);
    return {op, rd, rs, lo};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Offer one instruction, then record done/illegal/alu_b over READ, EXEC and WRITE
  task automatic issue(input logic [15:0] ins, output logic acc, output logic [2:0] dseq,
                       output logic ill, output logic [15:0] b);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      if (bus.instr_ready) acc = 1'b1;
    end
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 16'hFFFF;  // later changes must not affect the captured instruction
    dseq[0] = bus.done;
    @(negedge clk);
    dseq[1] = bus.done;
    b       = bus.alu_b;
    @(negedge clk);
    dseq[2] = bus.done;
    ill     = bus.illegal;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        acc;
    logic [2:0]  dseq;
    logic        ill;
    logic [15:0] b;

    n_pass  = 0;
    n_total = 0;
    tbl[0]  = '{5'b00010, 3'd2, 3'd0, 5'd1,     16'h0001, 4'b0000, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{5'b00110, 3'd1, 3'd0, 5'd0,     16'hFFFF, 4'b0010, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{5'b01010, 3'd1, 3'd1, 5'd0,     16'h7FFF, 4'b1000, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{5'b00000, 3'd3, 3'd1, 5'b01000, 16'h8000, 4'b0011, 1'b0, 1'b1, 16'h0001};
    tbl[4]  = '{5'b00010, 3'd1, 3'd0, 5'd5,     16'h0005, 4'b0000, 1'b0, 1'b0, 16'h0000};
    tbl[5]  = '{5'b00001, 3'd4, 3'd1, 5'b00100, 16'h0000, 4'b1100, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{5'b00011, 3'd5, 3'd1, 5'b00100, 16'h0005, 4'b1000, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{5'b00010, 3'd1, 3'd0, 5'd1,     16'h0001, 4'b0000, 1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{5'b00010, 3'd2, 3'd0, 5'd3,     16'h0003, 4'b0000, 1'b0, 1'b0, 16'h0000};
    tbl[9]  = '{5'b00010, 3'd2, 3'd2, 5'b11111, 16'h0002, 4'b1000, 1'b0, 1'b1, 16'hFFFF};
    tbl[10] = '{5'b01000, 3'd1, 3'd1, 5'd0,     16'h8000, 4'b1010, 1'b0, 1'b1, 16'h0001};
    tbl[11] = '{5'b01111, 3'd1, 3'd2, 5'b01100, 16'h8000, 4'b1010, 1'b1, 1'b0, 16'h0000};
    tbl[12] = '{5'b00100, 3'd7, 3'd2, 5'b01100, 16'h8002, 4'b1010, 1'b0, 1'b0, 16'h0000};

    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.dbg_addr    = 3'd0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {15'b0, bus.instr_ready}, 16'h0001);
    check("rst_done", {15'b0, bus.done}, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", {15'b0, bus.instr_ready}, 16'h0001);
    check("rst_flags", {12'b0, bus.flags}, 16'h0000);
    for (int r = 0; r < 8; r++) begin
      bus.dbg_addr = 3'(r);
      #1;
      check($sformatf("rst_r%0d", r), bus.dbg_data, 16'h0000);
    end

    for (int i = 0; i < 13; i++) begin
      issue(enc(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].lo), acc, dseq, ill, b);
      check($sformatf("row%0d_accept", i), {15'b0, acc}, 16'h0001);
      check($sformatf("row%0d_done_cycle", i), {13'b0, dseq}, 16'h0004);
      check($sformatf("row%0d_illegal", i), {15'b0, ill}, {15'b0, tbl[i].exp_ill});
      if (tbl[i].chk_b) check($sformatf("row%0d_alu_b", i), b, tbl[i].exp_b);
      bus.dbg_addr = tbl[i].rd;
      #1;
      check($sformatf("row%0d_reg", i), bus.dbg_data, tbl[i].exp_r);
      check($sformatf("row%0d_flags", i), {12'b0, bus.flags}, {12'b0, tbl[i].exp_f});
    end

    // Back-to-back: second ADDI offered during WRITE, must see the first result
    @(negedge clk);
    check("b2b_ready_idle", {15'b0, bus.instr_ready}, 16'h0001);
    bus.instr_valid = 1'b1;
    bus.instr       = enc(5'b00010, 3'd6, 3'd0, 5'd4);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = enc(5'b00010, 3'd6, 3'd6, 5'd1);
    #1;
    check("b2b_ready_in_write", {15'b0, bus.instr_ready}, 16'h0000);
    @(negedge clk);
    bus.dbg_addr = 3'd6;
    #1;
    check("b2b_ready_next_idle", {15'b0, bus.instr_ready}, 16'h0001);
    check("b2b_first_r6", bus.dbg_data, 16'h0004);
    @(negedge clk);
    check("b2b_accepted", {15'b0, bus.instr_ready}, 16'h0000);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_done", {15'b0, bus.done}, 16'h0001);
    @(negedge clk);
    #1;
    check("b2b_second_r6", bus.dbg_data, 16'h0005);

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = enc(5'b00010, 3'd6, 3'd6, 5'd3);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_done_low", {15'b0, bus.done}, 16'h0000);
    @(negedge clk);
    check("abort_done_in_rst", {15'b0, bus.done}, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("abort_ready", {15'b0, bus.instr_ready}, 16'h0001);
    check("abort_r6", bus.dbg_data, 16'h0000);
    check("abort_flags", {12'b0, bus.flags}, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_done%0d", k), {15'b0, bus.done}, 16'h0000);
    end

    // R0 is an ordinary writable register
    issue(enc(5'b00010, 3'd0, 3'd0, 5'd7), acc, dseq, ill, b);
    check("r0_done_cycle", {13'b0, dseq}, 16'h0004);
    bus.dbg_addr = 3'd0;
    #1;
    check("r0_write", bus.dbg_data, 16'h0007);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter FLAGS_INIT, default 4'b0000, reset value of the {c,z,n,o} flag register.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_valid  input  1  instruction offered.
REQ-005 SHALL have port instr_ready  output  1  block can accept an instruction.
REQ-006 SHALL have port instr  input  16  fields: [15:11] opcode, [10:8] rd, [7:5] rs, [4:2] rt, [4:0] imm5.
REQ-007 SHALL have ports alu_a, alu_b  output  16 each  ALU operands.
REQ-008 SHALL have port alu_s  output  4  ALU operation selector, equal to opcode[3:0].
REQ-009 SHALL have ports alu_r  input  16 and alu_c, alu_z, alu_n, alu_o  input  1 each  ALU result and flags, combinational from alu_a/alu_b/alu_s.
REQ-010 SHALL have port done  output  1  one-cycle pulse when an instruction retires.
REQ-011 SHALL have port illegal  output  1  one-cycle pulse, coincident with done, for an unsupported opcode.
REQ-012 SHALL have port flags  output  4  registered {c,z,n,o}.
REQ-013 SHALL have ports dbg_addr  input  3 and dbg_data  output  16  combinational register-file read.

Function
REQ-014 SHALL implement FSM states IDLE, READ, EXEC, WRITE; IDLE->READ on instr_valid&&instr_ready; READ->EXEC->WRITE->IDLE unconditionally.
REQ-015 SHALL assert instr_ready only in IDLE; instructions offered in any other state are not accepted.
REQ-016 SHALL capture instr into an internal register on acceptance; later changes on instr have no effect.
REQ-017 In READ SHALL latch opA=R[rs], and opB=R[rt] or, for ADDI (00010), imm5 sign-extended to 16 bits.
REQ-018 For ROR (01000) and ROL (01001) SHALL replace opB with {15'b0, flags.c}.
REQ-019 In EXEC SHALL drive alu_a=opA, alu_b=opB, alu_s=opcode[3:0] and latch alu_r and the four ALU flags at the end of the cycle; alu_a/alu_b/alu_s are don't-care in other states.
REQ-020 In WRITE SHALL write the latched result to R[rd] and pulse done; R0 is writable.
REQ-021 Flag update in WRITE: opcodes 00000-00010 update c,z,n,o; 00011-00111 update z,n only; 01000-01011 update c,z,n; unaffected bits hold.
REQ-022 Opcodes 01100-11111 SHALL be illegal: no register write, flags unchanged, illegal and done pulse together in WRITE.
REQ-023 Latency SHALL be fixed: acceptance edge at cycle 0, done high during cycle 3; maximum throughput one instruction per 4 cycles.
REQ-024 Back-to-back: an instruction held valid during WRITE SHALL be accepted in the following IDLE cycle and SHALL read the register value written by the previous instruction.
REQ-025 dbg_data SHALL show R[dbg_addr] with writes visible the cycle after the WRITE edge.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, R0-R7=16'h0000, flags=FLAGS_INIT, done=0, illegal=0, captured instruction and operand/result latches=0.
REQ-027 Reset asserted mid-instruction SHALL abort it with no register or flag write and no done pulse.
REQ-028 instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 Opcode constants (ADD..SHL), the state enum, and the instruction field positions SHALL live in a shared package cpu_pkg used by this block and its controller.
REQ-030 The 8x16 register file with one synchronous write port and three combinational read ports (rs, rt, dbg) SHALL be a sub-module regfile.
REQ-031 The ALU SHALL remain external; exec_ctrl SHALL contain no arithmetic beyond sign-extension and muxing.

Verification
REQ-032 R1=16'h7FFF, R2=16'h0001, ADD rd=3 rs=1 rt=2 -> done at cycle 3, R3=16'h8000, flags c=0 z=0 n=1 o=1.
REQ-033 R1=5, SUB rd=4 rs=1 rt=1 -> R4=0, z=1, n=0, o=0, c per ALU convention (1); then AND rd=5 rs=1 rt=1 -> R5=5, z=0, c/o unchanged.
REQ-034 ADDI rd=2 rs=2 imm5=5'b11111 with R2=3 -> R2=2 (imm=-1); flags c=1, o=0.
REQ-035 flags.c=1, R1=16'h0001, ROR rd=1 rs=1 -> alu_b=16'h0001 during EXEC; R1 and c from the ALU result.
REQ-036 Opcode 01111 -> illegal and done pulse in cycle 3, all registers and flags unchanged; the next valid instruction is accepted normally.
REQ-037 rst_n pulsed low during EXEC of a write to R6=16'h1234 -> R6=0, no done, instr_ready=1 after release.
